// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants, FSM state encoding and address-field helpers for the
// direct-mapped data cache datapath (cache_line_store).
//   Word address layout: { tag[TAG_W] | index[INDEX_W] | offset[OFFSET_W] }
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << (INDEX_W + OFFSET_W);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_FILL    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_sram.sv
// ---------------------------------------------------------------------------
// cache_sram
// Synchronous single-port RAM, one read or write per cycle. A write cycle
// returns the old contents on rdata (read-before-write).
//   clk    in   clock
//   we     in   write enable
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data, valid the cycle after addr is applied
// ---------------------------------------------------------------------------
module cache_sram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would prevent RAM
  // inference, and line validity is tracked separately by resettable bits.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_line_store.sv
// ---------------------------------------------------------------------------
// cache_line_store
// Direct-mapped read-only data cache datapath: tag/valid/data arrays, hit
// detection and 4-beat line refill from main memory. One request at a time.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   req_valid     in   lookup request
//   req_addr      in   word address, sampled when req_valid && req_ready
//   req_ready     out  idle, can accept a request
//   resp_valid    out  one-cycle response strobe
//   resp_hit      out  1 = hit, 0 = serviced by refill
//   resp_data     out  requested word
//   mem_rd_req    out  refill read request (level)
//   mem_rd_addr   out  word address of the current refill beat
//   mem_rd_valid  in   memory returns one beat this cycle
//   mem_rd_data   in   beat data
//   hit_count     out  (CACHE_STATS_EN) saturating hit counter
//   miss_count    out  (CACHE_STATS_EN) saturating miss counter
// ---------------------------------------------------------------------------
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  state_t state, state_next;

  logic [ADDR_W-1:0]   addr_q;
  logic [OFFSET_W-1:0] beat_q;
  logic [LINES-1:0]    valid_q;

  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  index_q;
  logic [OFFSET_W-1:0] offset_q;

  logic [TAG_W-1:0]            tag_rdata;
  logic [DATA_W-1:0]           data_rdata;
  logic [INDEX_W-1:0]          tag_ram_addr;
  logic [INDEX_W+OFFSET_W-1:0] data_ram_addr;

  logic lookup_hit;
  logic fill_beat;
  logic beat_last;

  assign tag_q    = addr_tag(addr_q);
  assign index_q  = addr_index(addr_q);
  assign offset_q = addr_offset(addr_q);

  // In IDLE the arrays are addressed straight from req_addr so their
  // synchronous read data is already available during LOOKUP.
  assign tag_ram_addr  = (state == ST_IDLE) ? addr_index(req_addr) : index_q;
  assign data_ram_addr = (state == ST_IDLE) ? {addr_index(req_addr), addr_offset(req_addr)}
                                            : {index_q, beat_q};

  assign lookup_hit = valid_q[index_q] && (tag_rdata == tag_q);
  assign fill_beat  = (state == ST_FILL) && mem_rd_valid;
  assign beat_last  = (beat_q == {OFFSET_W{1'b1}});

  cache_sram #(.WIDTH(TAG_W), .DEPTH(LINES)) u_tag_ram (
    .clk   (clk),
    .we    (fill_beat && beat_last),
    .addr  (tag_ram_addr),
    .wdata (tag_q),
    .rdata (tag_rdata)
  );

  cache_sram #(.WIDTH(DATA_W), .DEPTH(WORDS)) u_data_ram (
    .clk   (clk),
    .we    (fill_beat),
    .addr  (data_ram_addr),
    .wdata (mem_rd_data),
    .rdata (data_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        state_next = lookup_hit ? ST_RESPOND : ST_FILL;
      end
      ST_FILL: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {tag_q, index_q, beat_q};
        if (fill_beat && beat_last) state_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      beat_q    <= '0;
      valid_q   <= '0;
      resp_hit  <= 1'b0;
      resp_data <= '0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
      end

      if (state == ST_LOOKUP) begin
        beat_q   <= '0;
        resp_hit <= lookup_hit;
        if (lookup_hit) resp_data <= data_rdata;
      end

      if (fill_beat) begin
        if (beat_q == offset_q) resp_data <= mem_rd_data;
        if (beat_last) begin
          // Line becomes valid only once all four words are written.
          valid_q[index_q] <= 1'b1;
          beat_q           <= '0;
        end else begin
          beat_q <= beat_q + 2'd1;
        end
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_RESPOND) begin
      if (resp_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_line_store.sv
// ---------------------------------------------------------------------------
// tb_cache_line_store
// Self-checking bench for cache_line_store. Main memory and the cache
// contents are modelled as plain arrays: a line is present when its index
// was last filled with the same tag since the last reset, and any word read
// must equal main memory. Refill beats are served with directed or random
// stall patterns. Stats counters are checked when CACHE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cache_line_store;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
`ifdef CACHE_STATS_EN
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;
`endif

  cache_line_store dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_data    (resp_data),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [31:0]      main_mem [1 << ADDR_W];
  bit               model_valid [1024];
  int               model_tag   [1024];
  int               model_hits  = 0;
  int               model_misses = 0;
  bit               stall_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) model_valid[i] = 1'b0;
    model_hits   = 0;
    model_misses = 0;
  endtask

  // mode 0: memory always ready; 1: fixed stall pattern then a stray beat
  // during the response cycle; 2: random stalls.
  task automatic do_read(input int addr, input int mode);
    int          line_base;
    int          idx;
    int          tg;
    bit          exp_hit;
    int          beats;
    int          cyc;
    bit          v;
    logic [31:0] exp_data;
    line_base = addr & ~3;
    idx       = (addr / 4) % 1024;
    tg        = addr / 4096;
    exp_hit   = model_valid[idx] && (model_tag[idx] == tg);
    exp_data  = main_mem[addr];
    beats     = 0;
    cyc       = 0;

    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr[ADDR_W-1:0];
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ADDR_W'($urandom);
    check("lookup_ready_low", req_ready, 1'b0);
    check("lookup_no_resp", resp_valid, 1'b0);
    check("lookup_no_memreq", mem_rd_req, 1'b0);

    if (!exp_hit) begin
      @(negedge clk);
      while (beats < 4 && cyc < 64) begin
        check("fill_req", mem_rd_req, 1'b1);
        check("fill_addr", 32'(mem_rd_addr), 32'(line_base + beats));
        check("fill_no_resp", resp_valid, 1'b0);
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc < 7) ? stall_pat[cyc] : 1'b1;
          default: v = 1'($urandom_range(0, 1));
        endcase
        mem_rd_valid = v;
        mem_rd_data  = v ? main_mem[line_base + beats] : $urandom;
        @(negedge clk);
        if (v) beats++;
        cyc++;
      end
      if (beats < 4) check("fill_timeout", 32'(beats), 32'd4);
      mem_rd_valid = (mode == 1);
      mem_rd_data  = 32'hDEAD_BEEF;
    end else begin
      @(negedge clk);
    end

    check("resp_valid", resp_valid, 1'b1);
    check("resp_hit", resp_hit, exp_hit);
    check("resp_data", resp_data, exp_data);
    check("resp_no_memreq", mem_rd_req, 1'b0);
    @(negedge clk);
    mem_rd_valid = 1'b0;
    check("resp_one_cycle", resp_valid, 1'b0);
    check("ready_again", req_ready, 1'b1);

    model_valid[idx] = 1'b1;
    model_tag[idx]   = tg;
    if (exp_hit) begin
      if (model_hits < 16'hFFFF) model_hits++;
    end else begin
      if (model_misses < 16'hFFFF) model_misses++;
    end
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check("hit_count", 32'(hit_count), 32'(model_hits));
    check("miss_count", 32'(miss_count), 32'(model_misses));
`endif
  endtask

  initial begin
    int addr;
    int idx_pool [4] = '{5, 6, 7, 1023};

    for (int i = 0; i < (1 << ADDR_W); i++) main_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) main_mem[16 + i] = 32'hA0 + i;
    clear_model();

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_mem_rd_req", mem_rd_req, 1'b0);
    check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'h0);
    check_stats();
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, hit on the same line, conflict eviction and re-fetch
    do_read(32'h0012, 0);
    do_read(32'h0011, 0);
    do_read(32'h1012, 0);
    do_read(32'h0012, 0);
    // Stalled refill with a stray beat in the response cycle, then a hit
    // proving the stray beat did not overwrite the line
    do_read(32'h0123, 1);
    do_read(32'h0120, 0);
    do_read(32'h0123, 2);
    check_stats();

    // Reset during beat 2 of a refill to 0x0040
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 15'h0040;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = main_mem[32'h40 + b];
      @(negedge clk);
    end
    check("midfill_addr", 32'(mem_rd_addr), 32'h42);
    mem_rd_valid = 1'b1;
    mem_rd_data  = main_mem[32'h42];
    #2 rst = 1'b1;
    #1;
    check("rst_async_memreq", mem_rd_req, 1'b0);
    check("rst_async_resp", resp_valid, 1'b0);
    mem_rd_valid = 1'b0;
    clear_model();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_resp", resp_valid, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_resp", resp_valid, 1'b0);
      check("post_rst_ready", req_ready, 1'b1);
    end
    do_read(32'h0041, 0);
    do_read(32'h0043, 0);
    check_stats();

    // Randomized reads over a few indices to mix hits and conflicts
    for (int n = 0; n < 40; n++) begin
      addr = (int'($urandom_range(0, 7)) * 4096)
           + (idx_pool[$urandom_range(0, 3)] * 4)
           + int'($urandom_range(0, 3));
      do_read(addr, int'($urandom_range(0, 2)));
    end
    check_stats();

`ifdef CACHE_STATS_EN
    // Saturation: preload the hit counter at its maximum, then hit once more
    @(negedge clk);
    force dut.hit_count = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count;
    model_hits = 16'hFFFF;
    do_read(addr, 0);
    check_stats();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
